// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, branch-target register and return-address stack for the multicycle datapath.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          RAS_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  op,
   input  logic [31:0] off_sh,
   input  logic        br_cond,
   input  logic [25:0] jidx,
   output logic [31:0] pc,
   output logic [31:0] target,
   output logic        tgt_valid,
   output logic        taken,
   output logic        ras_empty,
   output logic        ras_full,
   output logic        err
);
   localparam int PW = $clog2(RAS_DEPTH) + 1;
   localparam logic [PW-1:0] FULL = PW'(RAS_DEPTH);
   localparam logic [2:0] OP_FETCH = 3'd1, OP_TGT = 3'd2, OP_BR = 3'd3,
                          OP_JMP = 3'd4, OP_CALL = 3'd5, OP_RET = 3'd6;
   typedef enum logic {EMPTY, VALID} state_t;
   state_t state, state_nx;
   logic [PW-1:0] ptr, ptr_nx;
   logic [31:0] ras [RAS_DEPTH];
   logic [31:0] pc_nx, target_nx, jpc;
   logic taken_nx, err_nx, push;
   assign tgt_valid = (state == VALID);
   assign jpc = {pc[31:28], jidx, 2'b00};
   always_comb begin
      state_nx  = state;
      pc_nx     = pc;
      target_nx = target;
      taken_nx  = 1'b0;
      err_nx    = err;
      ptr_nx    = ptr;
      push      = 1'b0;
      case (op)
         OP_FETCH: begin
            pc_nx    = pc + 32'd4;
            state_nx = EMPTY;
         end
         OP_TGT: begin
            target_nx = pc + off_sh;
            state_nx  = VALID;
         end
         OP_BR: begin
            state_nx = EMPTY;
            if (state == VALID) begin
               pc_nx    = br_cond ? target : pc;
               taken_nx = br_cond;
            end else
               err_nx = 1'b1;
         end
         OP_JMP: begin
            pc_nx    = jpc;
            taken_nx = 1'b1;
            state_nx = EMPTY;
         end
         OP_CALL: begin
            pc_nx    = jpc;
            taken_nx = 1'b1;
            state_nx = EMPTY;
            if (ptr == FULL)
               err_nx = 1'b1;
            else begin
               push   = 1'b1;
               ptr_nx = ptr + 1'b1;
            end
         end
         OP_RET: begin
            state_nx = EMPTY;
            if (ptr == '0)
               err_nx = 1'b1;
            else begin
               pc_nx    = ras[ptr[PW-2:0] - 1'b1];
               ptr_nx   = ptr - 1'b1;
               taken_nx = 1'b1;
            end
         end
         default: ;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         pc        <= RESET_PC;
         target    <= '0;
         taken     <= 1'b0;
         err       <= 1'b0;
         ptr       <= '0;
         ras_empty <= 1'b1;
         ras_full  <= 1'b0;
      end else begin
         state     <= state_nx;
         pc        <= pc_nx;
         target    <= target_nx;
         taken     <= taken_nx;
         err       <= err_nx;
         ptr       <= ptr_nx;
         ras_empty <= (ptr_nx == '0);
         ras_full  <= (ptr_nx == FULL);
      end
   end
   always_ff @(posedge clk) begin
      if (!rst && push)
         ras[ptr[PW-2:0]] <= pc;
   end
endmodule
